// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational integer ALU between two valid/ready requesters
// and registers the result, with requester ID and tag, into a single
// response slot.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
   parameter int TAG_W        = 4,
   parameter int PRIO_MODE    = 0,
   parameter int STARVE_LIMIT = 3
) (
   input  logic             clk,
   input  logic             resetn,

   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [63:0]      req0_opr_a_i,
   input  logic [63:0]      req0_opr_b_i,
   input  logic [3:0]       req0_alu_func_i,
   input  logic             req0_word_op_i,
   input  logic [TAG_W-1:0] req0_tag_i,

   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [63:0]      req1_opr_a_i,
   input  logic [63:0]      req1_opr_b_i,
   input  logic [3:0]       req1_alu_func_i,
   input  logic             req1_word_op_i,
   input  logic [TAG_W-1:0] req1_tag_i,

   output logic [63:0]      alu_opr_a_o,
   output logic [63:0]      alu_opr_b_o,
   output logic [3:0]       alu_func_o,
   output logic             alu_word_op_o,
   input  logic [63:0]      alu_res_i,

   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic             rsp_id_o,
   output logic [TAG_W-1:0] rsp_tag_o,
   output logic [63:0]      rsp_res_o
);

   // ALU function presented while nothing is granted
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

   logic       can_accept;
   logic       grant_vld;
   logic       grant_idx;
   logic       hs0;
   logic       hs1;
   logic       handshake;
   logic       last_grant;
   logic [3:0] starve_cnt;

   // The response slot can take a new result when empty or draining this cycle
   assign can_accept = !rsp_valid_o || rsp_ready_i;

   // Arbitration: pick a requester only when the response slot can take it
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = 1'b0;
      if (can_accept) begin
         if (PRIO_MODE == 0) begin
            if (req0_valid_i && req1_valid_i) begin
               grant_vld = 1'b1;
               grant_idx = !last_grant;
            end else if (req0_valid_i) begin
               grant_vld = 1'b1;
               grant_idx = 1'b0;
            end else if (req1_valid_i) begin
               grant_vld = 1'b1;
               grant_idx = 1'b1;
            end
         end else begin
            // Requester 1 wins when alone or once requester 0 has starved it long enough
            if (req1_valid_i && (!req0_valid_i || starve_cnt == LIMIT)) begin
               grant_vld = 1'b1;
               grant_idx = 1'b1;
            end else if (req0_valid_i) begin
               grant_vld = 1'b1;
               grant_idx = 1'b0;
            end
         end
      end
   end

   assign req0_ready_o = grant_vld && !grant_idx;
   assign req1_ready_o = grant_vld &&  grant_idx;
   assign hs0          = req0_valid_i && req0_ready_o;
   assign hs1          = req1_valid_i && req1_ready_o;
   assign handshake    = hs0 || hs1;

   // Steer the granted payload to the ALU; park on a zero ADD otherwise
   always_comb begin
      alu_opr_a_o   = 64'd0;
      alu_opr_b_o   = 64'd0;
      alu_func_o    = OP_ADD;
      alu_word_op_o = 1'b0;
      if (grant_vld) begin
         if (grant_idx) begin
            alu_opr_a_o   = req1_opr_a_i;
            alu_opr_b_o   = req1_opr_b_i;
            alu_func_o    = req1_alu_func_i;
            alu_word_op_o = req1_word_op_i;
         end else begin
            alu_opr_a_o   = req0_opr_a_i;
            alu_opr_b_o   = req0_opr_b_i;
            alu_func_o    = req0_alu_func_i;
            alu_word_op_o = req0_word_op_i;
         end
      end
   end

   // Arbitration history: last winner and requester-1 starvation count
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_grant <= 1'b1;
         starve_cnt <= 4'd0;
      end else begin
         if (handshake) begin
            last_grant <= grant_idx;
         end
         if (hs1 || !req1_valid_i) begin
            starve_cnt <= 4'd0;
         end else if (hs0 && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end

   // One-entry response slot: load on accept, clear valid on drain, hold data otherwise
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rsp_valid_o <= 1'b0;
         rsp_id_o    <= 1'b0;
         rsp_tag_o   <= '0;
         rsp_res_o   <= 64'd0;
      end else if (handshake) begin
         rsp_valid_o <= 1'b1;
         rsp_id_o    <= grant_idx;
         rsp_tag_o   <= grant_idx ? req1_tag_i : req0_tag_i;
         rsp_res_o   <= alu_res_i;
      end else if (rsp_ready_i) begin
         rsp_valid_o <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench: round-robin instance for most scenarios, fixed-priority
// instance (STARVE_LIMIT=2) for the starvation guard. A small ALU model
// closes the combinational loop for each instance.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_SLL = 4'd2;

   logic        clk;
   logic        resetn;

   // shared payload
   logic [63:0] a0, b0, a1, b1;
   logic [3:0]  f0, f1;
   logic        w0, w1;
   logic [3:0]  t0, t1;

   // round-robin instance
   logic        v0, v1, rdy0, rdy1, rsp_rdy;
   logic [63:0] alu_a, alu_b, alu_res, rsp_res;
   logic [3:0]  alu_f, rsp_tag;
   logic        alu_w, rsp_vld, rsp_id;

   // fixed-priority instance
   logic        pv0, pv1, prdy0, prdy1, p_rsp_rdy;
   logic [63:0] p_alu_a, p_alu_b, p_alu_res, p_rsp_res;
   logic [3:0]  p_alu_f, p_rsp_tag;
   logic        p_alu_w, p_rsp_vld, p_rsp_id;

   int n_tests;
   int n_fail;

   function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic [3:0] f, input logic w);
      logic [63:0] r;
      case (f)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_SLL:  r = w ? (a << b[4:0]) : (a << b[5:0]);
         default: r = 64'd0;
      endcase
      if (w) r = {{32{r[31]}}, r[31:0]};
      return r;
   endfunction

   assign alu_res   = alu_model(alu_a, alu_b, alu_f, alu_w);
   assign p_alu_res = alu_model(p_alu_a, p_alu_b, p_alu_f, p_alu_w);

   alu_arbiter #(.TAG_W(4), .PRIO_MODE(0), .STARVE_LIMIT(3)) u_rr (
      .clk(clk), .resetn(resetn),
      .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_opr_a_i(a0), .req0_opr_b_i(b0),
      .req0_alu_func_i(f0), .req0_word_op_i(w0), .req0_tag_i(t0),
      .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_opr_a_i(a1), .req1_opr_b_i(b1),
      .req1_alu_func_i(f1), .req1_word_op_i(w1), .req1_tag_i(t1),
      .alu_opr_a_o(alu_a), .alu_opr_b_o(alu_b), .alu_func_o(alu_f), .alu_word_op_o(alu_w),
      .alu_res_i(alu_res),
      .rsp_valid_o(rsp_vld), .rsp_ready_i(rsp_rdy), .rsp_id_o(rsp_id),
      .rsp_tag_o(rsp_tag), .rsp_res_o(rsp_res)
   );

   alu_arbiter #(.TAG_W(4), .PRIO_MODE(1), .STARVE_LIMIT(2)) u_prio (
      .clk(clk), .resetn(resetn),
      .req0_valid_i(pv0), .req0_ready_o(prdy0), .req0_opr_a_i(a0), .req0_opr_b_i(b0),
      .req0_alu_func_i(f0), .req0_word_op_i(w0), .req0_tag_i(t0),
      .req1_valid_i(pv1), .req1_ready_o(prdy1), .req1_opr_a_i(a1), .req1_opr_b_i(b1),
      .req1_alu_func_i(f1), .req1_word_op_i(w1), .req1_tag_i(t1),
      .alu_opr_a_o(p_alu_a), .alu_opr_b_o(p_alu_b), .alu_func_o(p_alu_f), .alu_word_op_o(p_alu_w),
      .alu_res_i(p_alu_res),
      .rsp_valid_o(p_rsp_vld), .rsp_ready_i(p_rsp_rdy), .rsp_id_o(p_rsp_id),
      .rsp_tag_o(p_rsp_tag), .rsp_res_o(p_rsp_res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // expected grant sequences
   logic rr_seq   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic pr_seq   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic clr_v1   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   logic clr_seq  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      n_tests = 0; n_fail = 0;
      resetn = 1'b0;
      v0 = 0; v1 = 0; pv0 = 0; pv1 = 0; rsp_rdy = 1'b1; p_rsp_rdy = 1'b1;
      a0 = 0; b0 = 0; a1 = 0; b1 = 0; f0 = OP_ADD; f1 = OP_ADD; w0 = 0; w1 = 0; t0 = 0; t1 = 0;

      // reset state
      #12;
      check("rst_valid", 64'(rsp_vld), 64'd0);
      check("rst_res",   rsp_res, 64'd0);
      check("rst_tag",   64'(rsp_tag), 64'd0);
      check("rst_id",    64'(rsp_id), 64'd0);
      @(negedge clk); resetn = 1'b1;
      #1;
      check("idle_func",  64'(alu_f), 64'(OP_ADD));
      check("idle_opr_a", alu_a, 64'd0);
      check("idle_ready", 64'({rdy0, rdy1}), 64'd0);

      // single request on requester 0
      @(negedge clk);
      v0 = 1; a0 = 64'd5; b0 = 64'd7; f0 = OP_ADD; t0 = 4'd3;
      #1;
      check("single_rdy0", 64'(rdy0), 64'd1);
      check("single_rdy1", 64'(rdy1), 64'd0);
      check("single_alu_a", alu_a, 64'd5);
      @(posedge clk); #1; v0 = 0;
      check("single_valid", 64'(rsp_vld), 64'd1);
      check("single_res",   rsp_res, 64'd12);
      check("single_id",    64'(rsp_id), 64'd0);
      check("single_tag",   64'(rsp_tag), 64'd3);

      // word-op SUB on requester 1
      @(negedge clk);
      v1 = 1; a1 = 64'd0; b1 = 64'd1; f1 = OP_SUB; w1 = 1; t1 = 4'd5;
      #1;
      check("wsub_rdy1", 64'(rdy1), 64'd1);
      check("wsub_word_op", 64'(alu_w), 64'd1);
      @(posedge clk); #1; v1 = 0;
      check("wsub_res", rsp_res, 64'hFFFF_FFFF_FFFF_FFFF);
      check("wsub_id",  64'(rsp_id), 64'd1);
      check("wsub_tag", 64'(rsp_tag), 64'd5);

      // SLL by 63 on requester 1
      @(negedge clk);
      v1 = 1; a1 = 64'd1; b1 = 64'd63; f1 = OP_SLL; w1 = 0; t1 = 4'd6;
      @(posedge clk); #1; v1 = 0;
      check("sll_res", rsp_res, 64'h8000_0000_0000_0000);
      check("sll_id",  64'(rsp_id), 64'd1);

      // round-robin with both requesters valid, consumer always ready
      @(negedge clk);
      v0 = 1; a0 = 64'd10; b0 = 64'd1; f0 = OP_ADD; w0 = 0; t0 = 4'd1;
      v1 = 1; a1 = 64'd20; b1 = 64'd2; f1 = OP_ADD; w1 = 0; t1 = 4'd2;
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("rr_rdy0_%0d", i), 64'(rdy0), 64'(!rr_seq[i]));
         check($sformatf("rr_rdy1_%0d", i), 64'(rdy1), 64'(rr_seq[i]));
         @(posedge clk); #1;
         check($sformatf("rr_valid_%0d", i), 64'(rsp_vld), 64'd1);
         check($sformatf("rr_id_%0d", i), 64'(rsp_id), 64'(rr_seq[i]));
         check($sformatf("rr_res_%0d", i), rsp_res, rr_seq[i] ? 64'd22 : 64'd11);
         @(negedge clk);
      end
      v0 = 0; v1 = 0;
      @(posedge clk); #1;
      check("rr_drain_valid", 64'(rsp_vld), 64'd0);

      // backpressure: pending response held while consumer stalls
      @(negedge clk);
      v0 = 1; a0 = 64'd3; b0 = 64'd4; f0 = OP_ADD; t0 = 4'd7;
      @(posedge clk); #1;
      rsp_rdy = 0;
      a0 = 64'd8; b0 = 64'd1; t0 = 4'd9;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check($sformatf("bp_rdy_%0d", i), 64'({rdy0, rdy1}), 64'd0);
         check($sformatf("bp_res_%0d", i), rsp_res, 64'd7);
         check($sformatf("bp_tag_%0d", i), 64'(rsp_tag), 64'd7);
         check($sformatf("bp_valid_%0d", i), 64'(rsp_vld), 64'd1);
      end
      @(negedge clk);
      rsp_rdy = 1;
      #1;
      check("bp_release_rdy0", 64'(rdy0), 64'd1);
      @(posedge clk); #1; v0 = 0;
      check("bp_reload_valid", 64'(rsp_vld), 64'd1);
      check("bp_reload_res",   rsp_res, 64'd9);
      check("bp_reload_tag",   64'(rsp_tag), 64'd9);
      @(posedge clk); #1;

      // starvation guard on the fixed-priority instance
      @(negedge clk);
      pv0 = 1; pv1 = 1;
      a0 = 64'd10; b0 = 64'd1; a1 = 64'd20; b1 = 64'd2; f0 = OP_ADD; f1 = OP_ADD;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check($sformatf("prio_id_%0d", i), 64'(p_rsp_id), 64'(pr_seq[i]));
         check($sformatf("prio_valid_%0d", i), 64'(p_rsp_vld), 64'd1);
      end
      // a cycle with requester 1 idle must reset the starvation count
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); pv1 = clr_v1[i];
         @(posedge clk); #1;
         check($sformatf("prio_clr_id_%0d", i), 64'(p_rsp_id), 64'(clr_seq[i]));
      end
      @(negedge clk); pv0 = 0; pv1 = 0;

      // asynchronous reset while a response is pending
      @(negedge clk);
      v0 = 1; a0 = 64'd1; b0 = 64'd1; t0 = 4'd4;
      @(posedge clk); #1; v0 = 0;
      check("mid_pre_valid", 64'(rsp_vld), 64'd1);
      #2 resetn = 1'b0;
      #1;
      check("mid_async_valid", 64'(rsp_vld), 64'd0);
      check("mid_async_res",   rsp_res, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      v0 = 1; v1 = 1;
      #1;
      check("post_rst_rdy0", 64'(rdy0), 64'd1);
      check("post_rst_rdy1", 64'(rdy1), 64'd0);
      @(posedge clk); #1; v0 = 0; v1 = 0;
      check("post_rst_id", 64'(rsp_id), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
